// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin write arbiter and sole writer of one shared register.
//            Optional owner lock is built when REGARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
`ifdef REGARB_LOCK_EN
  input  logic [N-1:0]       lock,
`endif
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   wr_count
);

  localparam int c_IW = (N > 1) ? $clog2(N) : 1;

`ifdef REGARB_LOCK_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_LOCKED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1} state_t;
`endif

  state_t             r_state;
  logic [c_IW-1:0]    r_last;
  logic [N-1:0]       r_gnt;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_valid;
  logic               r_busy;
  logic [CNT_W-1:0]   r_count;
`ifdef REGARB_LOCK_EN
  logic [c_IW-1:0]    r_owner;
  logic               w_lock_hold;
`endif

  logic [N-1:0]       w_req_eff;
  logic               w_any;
  logic               w_found;
  logic [c_IW-1:0]    w_idx;
  logic [c_IW-1:0]    w_win;
  logic [N-1:0]       w_onehot;
  logic [WIDTH-1:0]   w_data;

  always_comb begin
    w_req_eff = req;
`ifdef REGARB_LOCK_EN
    // While the owner keeps both req and lock high, nobody else is visible.
    w_lock_hold = (r_state == ST_LOCKED) && req[r_owner] && lock[r_owner];
    if (w_lock_hold) begin
      w_req_eff          = '0;
      w_req_eff[r_owner] = 1'b1;
    end
`endif
    w_any   = |w_req_eff;
    w_found = 1'b0;
    w_idx   = r_last;
    w_win   = r_last;
    // Scan starts just after the last winner, so it has lowest priority.
    for (int k = 1; k <= N; k++) begin
      w_idx = c_IW'((int'(r_last) + k) % N);
      if (!w_found && w_req_eff[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
    w_data          = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == c_IW'(i)) w_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= c_IW'(N - 1);
      r_gnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_count   <= '0;
`ifdef REGARB_LOCK_EN
      r_owner   <= '0;
`endif
    end else if (w_any) begin
      r_q       <= w_data;
      r_gnt     <= w_onehot;
      r_last    <= w_win;
      r_q_valid <= 1'b1;
      r_busy    <= 1'b1;
      if (r_count != '1) r_count <= r_count + 1'b1;
      r_state   <= ST_WRITE;
`ifdef REGARB_LOCK_EN
      // Locked grants keep last at the owner, so unlock needs no pointer fix-up.
      if (lock[w_win]) begin
        r_state <= ST_LOCKED;
        r_owner <= w_win;
      end
`endif
    end else begin
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_state <= ST_IDLE;
    end
  end

  assign gnt      = r_gnt;
  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign busy     = r_busy;
  assign wr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Directed self-checking bench for reg_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       lock;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   q;
  logic               q_valid;
  logic               busy;
  logic [CNT_W-1:0]   wr_count;

  int n_total;
  int n_pass;

  reg_write_arbiter #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wdata    (wdata),
`ifdef REGARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .q        (q),
    .q_valid  (q_valid),
    .busy     (busy),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    req     = '0;
    wdata   = '0;
    lock    = '0;
    step();
    step();
    chk("rst_gnt",      gnt,      0);
    chk("rst_q",        q,        0);
    chk("rst_q_valid",  q_valid,  0);
    chk("rst_busy",     busy,     0);
    chk("rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
    step();
    chk("idle_gnt", gnt, 0);

    // Single write from requester 0
    wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
    req   = 4'b0001;
    step();
    req   = 4'b0000;
    chk("single_gnt",     gnt,      4'b0001);
    chk("single_q",       q,        8'hA5);
    chk("single_q_valid", q_valid,  1);
    chk("single_count",   wr_count, 1);
    chk("single_busy",    busy,     1);
    step();
    chk("single_after_gnt",  gnt,  0);
    chk("single_after_busy", busy, 0);
    chk("single_after_q",    q,    8'hA5);

    // Fairness from a fresh reset: pointer at 3, so requester 0 first
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    req   = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_gnt", gnt, 32'(1) << (k % 4));
      chk("fair_q",   q,   32'(8'h10 + (k % 4)));
    end
    req = 4'b0000;
    chk("fair_count", wr_count, 8);
    step();
    chk("norq_gnt", gnt, 0);

    // Wrap from 3 to 0, then skip to 2
    req = 4'b0101;
    step();
    chk("wrap_gnt", gnt, 4'b0001);
    chk("wrap_q",   q,   8'h10);
    req = 4'b0100;
    step();
    chk("skip_gnt", gnt, 4'b0100);
    chk("skip_q",   q,   8'h12);
    req = 4'b0000;
    step();
    chk("hold_gnt",   gnt,      0);
    chk("hold_q",     q,        8'h12);
    chk("hold_busy",  busy,     0);
    chk("hold_count", wr_count, 10);

    // Reset in the middle of a burst, asserted between edges
    req = 4'b1111;
    step();
    chk("burst_gnt", gnt, 4'b1000);
    step();
    chk("burst_gnt2", gnt, 4'b0001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_gnt",     gnt,      0);
    chk("async_q",       q,        0);
    chk("async_q_valid", q_valid,  0);
    chk("async_busy",    busy,     0);
    chk("async_count",   wr_count, 0);
    step();
    chk("held_rst_gnt", gnt, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt",   gnt,      4'b0001);
    chk("post_rst_q",     q,        8'h10);
    chk("post_rst_count", wr_count, 1);
    req = 4'b0000;
    step();

`ifdef REGARB_LOCK_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 4'b0001;
    step();
    chk("lock_pre_gnt", gnt, 4'b0001);
    req  = 4'b0011;
    lock = 4'b0010;
    step();
    chk("lock_enter_gnt",  gnt,  4'b0010);
    chk("lock_enter_q",    q,    8'h11);
    chk("lock_enter_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_hold_gnt", gnt, 4'b0010);
    end
    lock = 4'b0000;
    step();
    chk("unlock_gnt", gnt, 4'b0001);
    chk("unlock_q",   q,   8'h10);
    req = 4'b0000;
    step();
    chk("unlock_idle_gnt", gnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
